// File: rtl/ddr_ctrl_pkg.sv
// Shared types and helpers for the DDR (MIG native app) burst controllers.
// Contents: one-hot controller state encoding, app_cmd opcodes, counter width helper.
package ddr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_WR_REQ = 3'b010,
    ST_WRITE  = 3'b100
  } state_t;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  // Width that holds 0..max_beats inclusive (max_beats is a power of 2).
  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/ddr_burst_wr_ctrl_if.sv
// MIG native app interface (command + write-data channels).
// master: controller side (drives cmd/en/addr/wdf_*), slave: MIG side (drives rdy/wdf_rdy).
interface ddr_burst_wr_ctrl_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned MASK_W = DATA_W / 8
);
  logic              app_rdy;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;

  modport master (
    input  app_rdy, app_wdf_rdy,
    output app_cmd, app_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    output app_rdy, app_wdf_rdy,
    input  app_cmd, app_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
  );
endinterface

// File: rtl/ddr_addr_gen.sv
// Circular frame address generator shared by the DDR read and write controllers.
// Ports: clk, rst_n (async active-low), step (advance by ADDR_STEP), sync (restart at
// FRAME_BASE, wins over step), addr (current command address).
module ddr_addr_gen #(
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int unsigned FRAME_WORDS = 786432
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              sync,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_BASE + FRAME_WORDS - ADDR_STEP);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);

  // Address register: sync restart has priority, last slot of the frame wraps to base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= BASE_A;
    end else if (sync) begin
      addr <= BASE_A;
    end else if (step) begin
      addr <= (addr == LAST_A) ? BASE_A : addr + STEP_A;
    end
  end

endmodule

// File: rtl/ddr_burst_wr_ctrl.sv
// Arbitrated DDR write-burst controller on the MIG native app interface.
// Ports: ui_clk, rst_n; wr_start/wr_len burst request; frame_sync address restart;
// data_req/wr_ddr_data/wr_ddr_mask FWFT source pull; wr_req/wr_ack arbiter handshake;
// wr_done completion pulse; wr_busy; app (MIG master side).
// Command and data beats are counted separately so stalls on either channel are absorbed.
module ddr_burst_wr_ctrl
  import ddr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned MASK_W      = DATA_W / 8,
  parameter int unsigned BURST_MAX   = 64,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int unsigned FRAME_WORDS = 786432,
  localparam int unsigned CNT_W      = cnt_width(BURST_MAX)
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic [CNT_W-1:0]  wr_len,
  input  logic              frame_sync,
  output logic              data_req,
  input  logic [DATA_W-1:0] wr_ddr_data,
  input  logic [MASK_W-1:0] wr_ddr_mask,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              wr_done,
  output logic              wr_busy,
  ddr_burst_wr_ctrl_if.master app
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(BURST_MAX);

  state_t            state;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  data_cnt;
  logic [CNT_W-1:0]  cmd_cnt;
  logic [CNT_W-1:0]  data_cnt_nx;
  logic [CNT_W-1:0]  cmd_cnt_nx;
  logic              sync_pend;
  logic              en_r;
  logic              wren_r;
  logic              beat_acc;
  logic              cmd_acc;
  logic              done_now;
  logic              done_nx;
  logic              addr_sync;
  logic [ADDR_W-1:0] addr;

  assign beat_acc    = wren_r & app.app_wdf_rdy;
  assign cmd_acc     = en_r & app.app_rdy;
  assign data_cnt_nx = data_cnt + CNT_W'(beat_acc);
  assign cmd_cnt_nx  = cmd_cnt + CNT_W'(cmd_acc);
  assign done_now    = (data_cnt == len_r) && (cmd_cnt == len_r);
  assign done_nx     = (data_cnt_nx == len_r) && (cmd_cnt_nx == len_r);

  // Restart immediately outside WRITE; inside WRITE defer to the exit cycle.
  assign addr_sync = ((state != ST_WRITE) && frame_sync) ||
                     ((state == ST_WRITE) && done_now && (sync_pend || frame_sync));

  ddr_addr_gen #(
    .ADDR_W      (ADDR_W),
    .ADDR_STEP   (ADDR_STEP),
    .FRAME_BASE  (FRAME_BASE),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .clk   (ui_clk),
    .rst_n (rst_n),
    .step  (cmd_acc),
    .sync  (addr_sync),
    .addr  (addr)
  );

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_r     <= '0;
      data_cnt  <= '0;
      cmd_cnt   <= '0;
      sync_pend <= 1'b0;
      wr_req    <= 1'b0;
      wr_done   <= 1'b0;
      en_r      <= 1'b0;
      wren_r    <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_start && (wr_len != '0)) begin
            state  <= ST_WR_REQ;
            len_r  <= (wr_len > LEN_MAX) ? LEN_MAX : wr_len;
            wr_req <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (wr_ack) begin
            state  <= ST_WRITE;
            wr_req <= 1'b0;
            wren_r <= 1'b1;
            en_r   <= 1'b1;
          end
        end
        ST_WRITE: begin
          data_cnt <= data_cnt_nx;
          cmd_cnt  <= cmd_cnt_nx;
          wren_r   <= (data_cnt_nx < len_r);
          // A command may only go out alongside or after its own data beat.
          en_r     <= (cmd_cnt_nx < len_r) && (cmd_cnt_nx <= data_cnt_nx);
          wr_done  <= done_nx && !done_now;
          if (frame_sync) begin
            sync_pend <= 1'b1;
          end
          if (done_now) begin
            state     <= ST_IDLE;
            data_cnt  <= '0;
            cmd_cnt   <= '0;
            sync_pend <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_busy          = (state == ST_WRITE);
  assign data_req         = beat_acc;
  assign app.app_cmd      = APP_CMD_WR;
  assign app.app_en       = en_r;
  assign app.app_addr     = addr;
  assign app.app_wdf_data = wr_ddr_data;
  assign app.app_wdf_wren = wren_r;
  assign app.app_wdf_end  = wren_r;
  assign app.app_wdf_mask = wr_ddr_mask;

endmodule

// File: tb/tb_ddr_burst_wr_ctrl.sv
// Scoreboard bench for ddr_burst_wr_ctrl: stimulus pushes expected command addresses,
// data beats and burst completions; a negedge monitor pops and compares them.
module tb_ddr_burst_wr_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 29;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned FRAME_WORDS = 64;
  localparam int unsigned STEP = 8;

  logic              ui_clk = 1'b0;
  logic              rst_n;
  logic              wr_start;
  logic [6:0]        wr_len;
  logic              frame_sync;
  logic              data_req;
  logic [DATA_W-1:0] wr_ddr_data;
  logic [MASK_W-1:0] wr_ddr_mask;
  logic              wr_req;
  logic              wr_ack;
  logic              wr_done;
  logic              wr_busy;

  ddr_burst_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) app ();

  ddr_burst_wr_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W), .BURST_MAX(64),
    .ADDR_STEP(STEP), .FRAME_BASE(0), .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .wr_start(wr_start), .wr_len(wr_len),
    .frame_sync(frame_sync), .data_req(data_req), .wr_ddr_data(wr_ddr_data),
    .wr_ddr_mask(wr_ddr_mask), .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done),
    .wr_busy(wr_busy), .app(app)
  );

  always #5 ui_clk = ~ui_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [MASK_W-1:0] exp_mask[$];
  int                exp_done[$];

  int src_idx = 0;     // FWFT source read pointer
  int exp_src = 0;     // next source index the model expects
  int model_addr = 0;
  int mon_beats = 0, mon_cmds = 0, req_cyc = 0, last_req_cyc = 0;
  int done_cnt = 0, n_done_exp = 0;
  int rdy_mode = 0, busy_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected / bound expired", name);
  endtask

  // FWFT source FIFO model
  always @(posedge ui_clk) if (data_req) src_idx <= src_idx + 1;
  assign wr_ddr_data = 32'hA500_0000 + src_idx[31:0];
  assign wr_ddr_mask = src_idx[3:0];

  // MIG ready pattern generator
  always @(posedge ui_clk) begin
    #2;
    if (wr_busy) busy_cyc++; else busy_cyc = 0;
    if (rdy_mode == 0) begin
      app.app_rdy = 1'b1;
      app.app_wdf_rdy = 1'b1;
    end else begin
      app.app_rdy = ~app.app_rdy;
      app.app_wdf_rdy = !(busy_cyc >= 10 && busy_cyc < 15);
    end
  end

  // Monitor / scoreboard
  always @(negedge ui_clk) begin
    if (!rst_n) begin
      mon_beats = 0; mon_cmds = 0; req_cyc = 0;
    end else begin
      if (wr_req) req_cyc++;
      check("data_req", data_req, app.app_wdf_wren && app.app_wdf_rdy);
      check("wdf_end", app.app_wdf_end, app.app_wdf_wren);
      if (app.app_en) check("en_order", mon_cmds > mon_beats, 0);
      if (app.app_en && app.app_rdy) begin
        check("app_cmd", app.app_cmd, 3'b000);
        if (exp_addr.size() == 0) fail_now("extra_cmd");
        else check("cmd_addr", app.app_addr, exp_addr.pop_front());
        mon_cmds++;
      end
      if (app.app_wdf_wren && app.app_wdf_rdy) begin
        if (exp_data.size() == 0) fail_now("extra_beat");
        else begin
          check("wdf_data", app.app_wdf_data, exp_data.pop_front());
          check("wdf_mask", app.app_wdf_mask, exp_mask.pop_front());
        end
        mon_beats++;
      end
      if (wr_done) begin
        if (exp_done.size() == 0) fail_now("extra_wr_done");
        else begin
          int n;
          n = exp_done.pop_front();
          check("done_beats", mon_beats, n);
          check("done_cmds", mon_cmds, n);
        end
        done_cnt++;
        last_req_cyc = req_cyc;
        mon_beats = 0; mon_cmds = 0; req_cyc = 0;
      end
    end
  end

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ADDR_W'(model_addr));
      model_addr = (model_addr == FRAME_WORDS - STEP) ? 0 : model_addr + STEP;
      exp_data.push_back(32'hA500_0000 + 32'(exp_src));
      exp_mask.push_back(4'(exp_src));
      exp_src++;
    end
    exp_done.push_back(n);
  endtask

  task automatic start_burst(input int len, input int ack_dly);
    @(posedge ui_clk); #2;
    wr_start = 1'b1;
    wr_len = 7'(len);
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge ui_clk); #2;
      wr_start = 1'b0;
    end
    wr_ack = 1'b1;
    @(posedge ui_clk); #2;
    wr_ack = 1'b0;
  endtask

  task automatic wait_done(input int sync_at);
    bit pulsed = 1'b0;
    int c;
    n_done_exp++;
    for (c = 0; c < 3000; c++) begin
      @(posedge ui_clk); #2;
      frame_sync = 1'b0;
      if (done_cnt >= n_done_exp) break;
      if (sync_at >= 0 && !pulsed && wr_busy && app.app_addr == ADDR_W'(sync_at)) begin
        frame_sync = 1'b1;
        pulsed = 1'b1;
      end
    end
    frame_sync = 1'b0;
    if (c >= 3000) fail_now("done_timeout");
    check("busy_after_done", wr_busy, 0);
  endtask

  task automatic burst(input int len, input int eff, input int ack_dly);
    push_exp(eff);
    start_burst(len, ack_dly);
    wait_done(-1);
  endtask

  task automatic idle_sync();
    @(posedge ui_clk); #2;
    frame_sync = 1'b1;
    @(posedge ui_clk); #2;
    frame_sync = 1'b0;
    model_addr = 0;
    check("idle_sync_addr", app.app_addr, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr_req"}, wr_req, 0);
    check({tag, "_wr_done"}, wr_done, 0);
    check({tag, "_wr_busy"}, wr_busy, 0);
    check({tag, "_app_en"}, app.app_en, 0);
    check({tag, "_wren"}, app.app_wdf_wren, 0);
    check({tag, "_data_req"}, data_req, 0);
    check({tag, "_addr"}, app.app_addr, 0);
  endtask

  initial begin
    bit seen;
    int c;
    rst_n = 1'b0; wr_start = 1'b0; wr_len = '0; frame_sync = 1'b0; wr_ack = 1'b0;
    app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
    #13;
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge ui_clk);
    #2 check_quiet("post_reset");

    // Basic burst: addresses 0..24, wr_req held 3 cycles
    burst(4, 4, 3);
    check("wr_req_cycles", last_req_cyc, 3);
    // Continues from 32
    burst(2, 2, 1);
    check("wr_req_cycles2", last_req_cyc, 1);

    // Full burst with stalls on both channels
    rdy_mode = 1;
    burst(64, 64, 2);
    rdy_mode = 0;

    // Zero length is ignored
    @(posedge ui_clk); #2;
    wr_start = 1'b1; wr_len = 7'd0;
    @(posedge ui_clk); #2;
    wr_start = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge ui_clk);
      seen = seen | wr_req | wr_busy;
    end
    check("len0_ignored", seen, 0);

    // Frame wrap: second burst 48,56,0,8,16,24
    idle_sync();
    burst(6, 6, 1);
    burst(6, 6, 2);

    // Oversize length clamps to 64
    burst(100, 64, 1);

    // frame_sync during WRITE at address 40
    idle_sync();
    burst(3, 3, 1);
    push_exp(4);
    start_burst(4, 1);
    wait_done(40);
    model_addr = 0;
    check("sync_write_addr", app.app_addr, 0);
    burst(3, 3, 1);

    // Reset mid-burst after 10 beats
    push_exp(20);
    start_burst(20, 1);
    for (c = 0; c < 200; c++) begin
      @(negedge ui_clk); #1;
      if (mon_beats >= 10) break;
    end
    if (c >= 200) fail_now("ten_beats_timeout");
    rst_n = 1'b0;
    #1 check_quiet("mid_reset");
    exp_addr.delete(); exp_data.delete(); exp_mask.delete(); exp_done.delete();
    model_addr = 0;
    exp_src = src_idx;
    repeat (3) @(posedge ui_clk);
    #2 rst_n = 1'b1;
    burst(5, 5, 2);

    repeat (3) @(posedge ui_clk);
    check("left_addr", exp_addr.size(), 0);
    check("left_data", exp_data.size(), 0);
    check("left_done", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
